// File: rtl/instruction_memory.sv
// Instruction fetch memory: byte-serial big-endian program loader feeding a
// synchronous-read program store, with a registered fetch output that honours
// reset, flush, stall/halt and out-of-range addresses.
module instruction_memory #(
   parameter int NB_WIDTH  = 32,
   parameter int NB_BYTE   = 8,
   parameter int MEM_DEPTH = 256,
   localparam int NB_ADDR  = $clog2(MEM_DEPTH)
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic                i_load_en,
   input  logic [NB_BYTE-1:0]  i_load_byte,
   input  logic                i_load_clear,
   input  logic [NB_WIDTH-1:0] i_pcounter,
   input  logic                i_stall,
   input  logic                i_halt,
   input  logic                i_flush,
   output logic [NB_WIDTH-1:0] o_instruction,
   output logic                o_valid,
   output logic [NB_ADDR:0]    o_word_count,
   output logic                o_load_full,
   output logic                o_load_err
);

   localparam logic [NB_ADDR:0] FULL_COUNT = (NB_ADDR+1)'(MEM_DEPTH);
   localparam int               NB_SHIFT   = NB_WIDTH - NB_BYTE;
   localparam int               NB_HIGH    = NB_WIDTH - NB_ADDR - 2;

   // Program store; intentionally never reset so it maps onto block RAM.
   logic [NB_WIDTH-1:0] mem_r [MEM_DEPTH];

   logic [1:0]          byte_cnt_r,   byte_cnt_nxt_s;
   logic [NB_SHIFT-1:0] shift_r,      shift_nxt_s;
   logic [NB_ADDR:0]    word_count_r, word_count_nxt_s;
   logic                load_err_r,   load_err_nxt_s;
   logic                load_full_r;
   logic                is_full_s;
   logic                wr_en_s;
   logic [NB_WIDTH-1:0] wr_data_s;
   logic [NB_ADDR-1:0]  wr_idx_s;

   logic [NB_ADDR-1:0]  fetch_idx_s;
   logic [NB_HIGH-1:0]  pc_high_s;
   logic                in_range_s;
   logic                unused_pc_bits_s;

   assign is_full_s        = (word_count_r == FULL_COUNT);
   assign fetch_idx_s      = i_pcounter[NB_ADDR+1:2];
   assign pc_high_s        = i_pcounter[NB_WIDTH-1:NB_ADDR+2];
   // Byte offset within a word does not select anything.
   assign unused_pc_bits_s = ^i_pcounter[1:0];

   // Loader next-state: assemble bytes MSB-first, commit a word on the 4th byte.
   always_comb begin
      byte_cnt_nxt_s   = byte_cnt_r;
      shift_nxt_s      = shift_r;
      word_count_nxt_s = word_count_r;
      load_err_nxt_s   = load_err_r;
      wr_en_s          = 1'b0;
      wr_data_s        = {shift_r, i_load_byte};
      wr_idx_s         = word_count_r[NB_ADDR-1:0];
      if (i_load_clear) begin
         byte_cnt_nxt_s   = 2'd0;
         word_count_nxt_s = {(NB_ADDR+1){1'b0}};
         load_err_nxt_s   = 1'b0;
      end else if (i_load_en) begin
         if (is_full_s) begin
            load_err_nxt_s = 1'b1;
         end else begin
            shift_nxt_s = {shift_r[NB_SHIFT-NB_BYTE-1:0], i_load_byte};
            if (byte_cnt_r == 2'd3) begin
               wr_en_s          = ~i_rst;
               byte_cnt_nxt_s   = 2'd0;
               word_count_nxt_s = word_count_r + {{NB_ADDR{1'b0}}, 1'b1};
            end else begin
               byte_cnt_nxt_s = byte_cnt_r + 2'd1;
            end
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Loader bookkeeping registers; reset also discards any partial word.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         byte_cnt_r   <= 2'd0;
         shift_r      <= {NB_SHIFT{1'b0}};
         word_count_r <= {(NB_ADDR+1){1'b0}};
         load_err_r   <= 1'b0;
         load_full_r  <= 1'b0;
      end else begin
         byte_cnt_r   <= byte_cnt_nxt_s;
         shift_r      <= shift_nxt_s;
         word_count_r <= word_count_nxt_s;
         load_err_r   <= load_err_nxt_s;
         load_full_r  <= (word_count_nxt_s == FULL_COUNT);
      end
   end

   // Program store write port.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_idx_s] <= wr_data_s;
      end
   end

   // A fetch is valid only for fully loaded words below the pre-edge count.
   always_comb begin
      in_range_s = 1'b0;
      if (pc_high_s == {NB_HIGH{1'b0}}) begin
         in_range_s = ({1'b0, fetch_idx_s} < word_count_r);
      end else begin
         in_range_s = 1'b0;
      end
   end

   // Registered fetch output: reset > flush > stall/halt hold > read.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         o_instruction <= {NB_WIDTH{1'b0}};
         o_valid       <= 1'b0;
      end else if (i_flush) begin
         o_instruction <= {NB_WIDTH{1'b0}};
         o_valid       <= 1'b0;
      end else if (i_stall || i_halt) begin
         o_instruction <= o_instruction;
         o_valid       <= o_valid;
      end else if (in_range_s) begin
         o_instruction <= mem_r[fetch_idx_s];
         o_valid       <= 1'b1;
      end else begin
         o_instruction <= {NB_WIDTH{1'b0}};
         o_valid       <= 1'b0;
      end
   end

   assign o_word_count = word_count_r;
   assign o_load_full  = load_full_r;
   assign o_load_err   = load_err_r;

endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Instruction-fetch stage directly downstream of program_counter: takes the PC byte address and returns the registered 32-bit instruction to the IF/ID boundary.
- Holds a loadable program store filled byte-serially by the debug/loader path (UART side) before execution.
- Provides load bookkeeping (word count, full, overflow error) for the debug unit.

Parameters:
- NB_WIDTH, 32, instruction and PC width
- NB_BYTE, 8, loader byte width
- MEM_DEPTH, 256, program store depth in 32-bit words; power of two, >= 2
- NB_ADDR, clog2(MEM_DEPTH), word index width (derived, localparam)

Ports:
- clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_load_en  in  1  loader byte valid, one byte per asserted cycle
- i_load_byte  in  NB_BYTE  loader byte
- i_load_clear  in  1  restart program load (pointer/count/flags to zero)
- i_pcounter  in  NB_WIDTH  byte address from program_counter (o_pcounter)
- i_stall  in  1  hazard stall: hold output
- i_halt  in  1  debug halt: hold output
- i_flush  in  1  branch/jump taken: squash fetched instruction
- o_instruction  out  NB_WIDTH  fetched instruction, registered
- o_valid  out  1  o_instruction is a loaded word
- o_word_count  out  NB_ADDR+1  number of complete words loaded
- o_load_full  out  1  o_word_count == MEM_DEPTH
- o_load_err  out  1  sticky: byte offered while full

Behaviour:
- Reset (i_rst=1 at edge): o_instruction=0, o_valid=0, o_word_count=0, o_load_full=0, o_load_err=0, byte counter=0, partial word discarded. Memory array is not cleared.
- Loader, big-endian: 1st byte of a word -> [31:24], 2nd -> [23:16], 3rd -> [15:8], 4th -> [7:0].
  - On the 4th byte the assembled word is written to mem[o_word_count]; o_word_count increments the same edge.
  - 2-bit byte counter wraps 3->0.
- Full: when o_word_count == MEM_DEPTH, o_load_full=1.
  - Further i_load_en bytes are dropped; memory and counters are unchanged.
  - o_load_err sets on the first dropped byte and stays set until i_load_clear or i_rst.
- i_load_clear: byte counter, o_word_count, o_load_full and o_load_err go to 0; memory contents are kept.
  - Clear has priority over an i_load_en in the same cycle; that byte is dropped.
- Fetch: word index = i_pcounter[NB_ADDR+1:2]; i_pcounter[1:0] are ignored.
- Out of range: i_pcounter[NB_WIDTH-1:NB_ADDR+2] != 0, or index >= o_word_count.
- Latency is 1 cycle: the value sampled at edge N is visible after edge N.
- Priority at each edge: i_rst > i_flush > (i_stall | i_halt) > fetch.
  - flush: o_instruction=0 (NOP), o_valid=0.
  - stall/halt: o_instruction and o_valid are held.
  - fetch, in range: o_instruction=mem[index], o_valid=1.
  - fetch, out of range: o_instruction=0, o_valid=0.
- Read/write to the same index in the same cycle is read-first: the fetch returns the old content, and that index is still out of range if it equals the pre-edge count.
- Loading is independent of stall/halt/flush; loading while fetching is legal.
- The memory is a synchronous-read array and must be inferable as block RAM (no reset on the array).

Test Plan:
1. Reset, then load bytes 20 08 00 05 8C 09 00 04 -> o_word_count=2. Drive i_pcounter=0 -> next cycle o_instruction=0x20080005, o_valid=1. Drive i_pcounter=4 -> 0x8C090004.
2. Same program, i_pcounter=8, then 0x00010000 -> o_instruction=0, o_valid=0 both times.
3. Fetching 0x20080005, assert i_stall for 2 cycles while i_pcounter=4 -> output holds 0x20080005. Release -> 0x8C090004 one cycle later. Repeat with i_halt: same result.
4. i_flush=1 together with i_stall=1 at i_pcounter=4 -> o_instruction=0, o_valid=0. Next cycle with no flush/stall -> 0x8C090004, o_valid=1.
5. MEM_DEPTH=4: load 16 bytes -> o_word_count=4, o_load_full=1, o_load_err=0. 17th byte -> o_load_err=1, count stays 4. i_load_clear -> count 0, full 0, err 0. Load 11 22 33 44, fetch pc=0 -> 0x11223344.
6. Load bytes AA BB, assert i_rst one cycle, then load 01 02 03 04 -> o_word_count=1; fetch pc=0 -> 0x01020304 (partial word discarded).
